i2s_slave_tx: RTL

- I2S slave transmitter: the TX-direction counterpart of the I2S slave RX path on the AL4S3B.
- Accepts stereo sample words from the Wishbone/DMA side into a small FIFO.
- Serialises the words onto i2s_dat_o, timed by the externally mastered I2S bit clock and word select.
- All logic runs on wbs_clk_i; BCLK and WS are oversampled through synchronisers and edge detectors. No gated or derived clocks.

---
 rtl/i2s_slave_tx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/i2s_slave_tx.sv
// rtl/i2s_slave_tx.sv - I2S slave transmitter: stereo FIFO serialised on external BCLK/WS
module i2s_slave_tx #(
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                         wbs_clk_i,
  input  logic                         wbs_rst_n_i,
  input  logic                         i2s_en_i,
  input  logic                         i2s_clk_i,
  input  logic                         i2s_ws_i,
  output logic                         i2s_dat_o,
  input  logic [2*DATA_WIDTH-1:0]      tx_dat_i,
  input  logic                         tx_push_i,
  output logic                         tx_full_o,
  output logic [FIFO_ADDR_WIDTH:0]     tx_level_o,
  output logic                         underrun_o,
  output logic                         overflow_o,
  input  logic                         err_clr_i,
  output logic [15:0]                  frame_cnt_o
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int LW    = FIFO_ADDR_WIDTH + 1;
  localparam int CW    = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t state_q, state_d;

  logic [2:0] bclk_sync, ws_sync;
  logic       bclk_rise, bclk_fall;
  logic       rise_d, ws_q, ws_prev, start_pend, slot_start;

  logic [2*DATA_WIDTH-1:0]    mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]              level;
  logic [2*DATA_WIDTH-1:0]    pop_data;
  logic                       fifo_empty, fifo_full;

  logic [DATA_WIDTH-1:0] shreg, right_hold;
  logic [CW-1:0]         bit_cnt;

  logic active, slot_go, load_left, load_right, shift_go, pop, push_ok, push_drop;

  // Bring the asynchronous BCLK and WS into the system clock domain
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
    if (!wbs_rst_n_i) begin
      bclk_sync <= '0;
      ws_sync   <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], i2s_clk_i};
      ws_sync   <= {ws_sync[1:0], i2s_ws_i};
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
  assign bclk_fall = ~bclk_sync[1] & bclk_sync[2];

  // Capture WS on each BCLK rise and flag a pending slot start when it changes
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
    if (!wbs_rst_n_i) begin
      rise_d     <= 1'b0;
      ws_q       <= 1'b0;
      ws_prev    <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      rise_d <= bclk_rise;
      if (bclk_rise) begin
        ws_q    <= ws_sync[2];
        ws_prev <= ws_q;
      end
      if (bclk_fall)       start_pend <= 1'b0;
      else if (slot_start) start_pend <= 1'b1;
    end
  end

  assign slot_start = rise_d & (ws_q != ws_prev);

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(DEPTH));
  assign pop_data   = mem[rd_ptr];

  assign active     = i2s_en_i & (state_q != IDLE);
  assign slot_go    = bclk_fall & start_pend & active;
  assign load_left  = slot_go & ~ws_q;
  assign load_right = slot_go & ws_q & (state_q == RUN);
  assign shift_go   = bclk_fall & ~start_pend & active & (state_q == RUN);
  assign pop        = load_left & ~fifo_empty;
  assign push_ok    = tx_push_i & i2s_en_i & ~fifo_full;
  assign push_drop  = tx_push_i & fifo_full;

  // State register
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
    if (!wbs_rst_n_i) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next state: arm on enable, start running only on a left slot, drop to idle on disable
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i2s_en_i) state_d = ARM;
      ARM:     if (load_left) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (!i2s_en_i) state_d = IDLE;
  end

  // FIFO storage; contents only matter behind the pointers
  always_ff @(posedge wbs_clk_i) begin
    if (push_ok) mem[wr_ptr] <= tx_dat_i;
  end

  // FIFO pointers and occupancy, held flushed while disabled
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
    if (!wbs_rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (!i2s_en_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Serialiser: load MSB at slot start, shift on later BCLK falls, pad with zeros
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
    if (!wbs_rst_n_i) begin
      shreg      <= '0;
      right_hold <= '0;
      bit_cnt    <= '0;
      i2s_dat_o  <= 1'b0;
    end else if (!active) begin
      shreg      <= '0;
      right_hold <= '0;
      bit_cnt    <= '0;
      i2s_dat_o  <= 1'b0;
    end else if (load_left) begin
      if (!fifo_empty) begin
        shreg      <= pop_data[2*DATA_WIDTH-1:DATA_WIDTH];
        right_hold <= pop_data[DATA_WIDTH-1:0];
        i2s_dat_o  <= pop_data[2*DATA_WIDTH-1];
      end else begin
        shreg      <= '0;
        right_hold <= '0;
        i2s_dat_o  <= 1'b0;
      end
      bit_cnt <= CW'(DATA_WIDTH-1);
    end else if (load_right) begin
      shreg     <= right_hold;
      i2s_dat_o <= right_hold[DATA_WIDTH-1];
      bit_cnt   <= CW'(DATA_WIDTH-1);
    end else if (shift_go) begin
      if (bit_cnt != '0) begin
        shreg     <= shreg << 1;
        i2s_dat_o <= shreg[DATA_WIDTH-2];
        bit_cnt   <= bit_cnt - CW'(1);
      end else begin
        i2s_dat_o <= 1'b0;
      end
    end
  end

  // Sticky error flags (set beats clear) and left-slot frame counter
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
    if (!wbs_rst_n_i) begin
      underrun_o  <= 1'b0;
      overflow_o  <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      if (load_left & fifo_empty) underrun_o <= 1'b1;
      else if (err_clr_i)         underrun_o <= 1'b0;
      if (push_drop)              overflow_o <= 1'b1;
      else if (err_clr_i)         overflow_o <= 1'b0;
      if (load_left)              frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end

  assign tx_full_o  = fifo_full;
  assign tx_level_o = level;

endmodule
